rx_burst_capture: RTL

RX_BURST_CAPTURE -- requirements
Module: rx_burst_capture

---
 rtl/rx_burst_capture.sv | 95 +++++++++
 1 files changed

// File: rtl/rx_burst_capture.sv
// rx_burst_capture: ring-buffered capture of IQ sample bursts around a packet-detect trigger.
// The capture starts up to cfg_pre_len samples before the trigger and is delivered over a valid/ready output.
module rx_burst_capture #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_real,
   input  logic [DATA_WIDTH-1:0] in_imag,
   input  logic                  packet_detect,
   input  logic                  cfg_enable,
   input  logic [4:0]            cfg_pre_len,
   input  logic [11:0]           cfg_burst_len,
   input  logic                  overflow_clr,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_real,
   output logic [DATA_WIDTH-1:0] out_imag,
   output logic                  out_first,
   output logic                  out_last,
   output logic                  busy,
   output logic                  overflow,
   output logic [15:0]           burst_count
);
   localparam int DEPTH = 1 << ADDR_WIDTH;
   typedef enum logic {IDLE, CAPTURE} state_t;
   state_t state, state_next;
   logic [2*DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0] wr_ptr, rd_ptr, occ;
   logic [ADDR_WIDTH-1:0] fill;
   logic [12:0] remaining, pre_eff, burst_eff;
   logic first_pend, trig, ovf, load;
   always_comb begin
      occ = wr_ptr - rd_ptr;
      pre_eff = (13'(cfg_pre_len) < 13'(fill)) ? 13'(cfg_pre_len) : 13'(fill);
      burst_eff = (cfg_burst_len == '0) ? 13'd1 : 13'(cfg_burst_len);
      trig = state == IDLE && in_valid && packet_detect && cfg_enable;
      // occupancy never exceeds DEPTH, so its MSB alone flags a full ring
      ovf = state == CAPTURE && in_valid && occ[ADDR_WIDTH] && remaining != '0;
      load = state == CAPTURE && remaining != '0 && occ != '0 && (!out_valid || out_ready) && !ovf;
      state_next = trig ? CAPTURE : (ovf || (load && remaining == 13'd1)) ? IDLE : state;
   end
   always_ff @(posedge clock)
      if (reset) state <= IDLE;
      else state <= state_next;
   always_ff @(posedge clock)
      if (in_valid) mem[wr_ptr[ADDR_WIDTH-1:0]] <= {in_imag, in_real};
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill <= '0;
         remaining <= '0;
         first_pend <= 1'b0;
         out_valid <= 1'b0;
         out_first <= 1'b0;
         out_last <= 1'b0;
         out_real <= '0;
         out_imag <= '0;
         overflow <= 1'b0;
         burst_count <= '0;
      end else begin
         if (in_valid) begin
            wr_ptr <= wr_ptr + (ADDR_WIDTH+1)'(1);
            if (!(&fill)) fill <= fill + ADDR_WIDTH'(1);
         end
         if (trig) begin
            rd_ptr <= wr_ptr - pre_eff[ADDR_WIDTH:0];
            remaining <= pre_eff + burst_eff;
            first_pend <= 1'b1;
         end else if (ovf) remaining <= '0;
         else if (load) begin
            rd_ptr <= rd_ptr + (ADDR_WIDTH+1)'(1);
            remaining <= remaining - 13'd1;
         end
         if (load) begin
            {out_imag, out_real} <= mem[rd_ptr[ADDR_WIDTH-1:0]];
            out_valid <= 1'b1;
            out_first <= first_pend;
            out_last <= remaining == 13'd1;
            first_pend <= 1'b0;
         end else if (out_ready) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last <= 1'b0;
         end
         if (out_valid && out_ready && out_last) burst_count <= burst_count + 16'd1;
         if (ovf) overflow <= 1'b1;
         else if (overflow_clr) overflow <= 1'b0;
      end
   end
   assign busy = state == CAPTURE;
endmodule
